// File: rtl/fft_pkg.sv
// Shared definitions for the FFT channel arbiter slice: state encodings,
// default sizes and a counter-width helper.
package fft_pkg;

   localparam int FFT_N    = 16;
   localparam int SAMPLE_W = 16;

   typedef enum logic [1:0] {
      FA_IDLE = 2'b01,
      FA_BUSY = 2'b10
   } fa_state_e;

   // Bits needed to index n items; never less than one bit.
   function automatic int cnt_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/fft_tag_fifo.sv
// Small 1-bit tag FIFO with a show-ahead head; push and pop may coincide.
module fft_tag_fifo
   import fft_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        push,
   input  logic                        push_tag,
   input  logic                        pop,
   output logic                        head,
   output logic                        full,
   output logic                        empty,
   output logic [cnt_w(DEPTH+1)-1:0]   count
);

   localparam int PW = cnt_w(DEPTH);
   localparam int CW = cnt_w(DEPTH + 1);

   logic [DEPTH-1:0] mem;
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign empty   = (count == '0);
   assign full    = (count == CW'(DEPTH));
   assign head    = mem[rd_ptr];
   // A pop frees a slot in the same cycle, so a push into a full FIFO is legal then.
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);

   always_ff @(posedge clk) begin
      if (reset) begin
         mem    <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= push_tag;
            wr_ptr      <= next_ptr(wr_ptr);
         end
         if (do_pop) begin
            rd_ptr <= next_ptr(rd_ptr);
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/fft_chan_arbiter.sv
// Round-robin frame arbiter sharing one FFT core between two sample streams,
// tagging each core output sample with the channel that owned its frame.
module fft_chan_arbiter
   import fft_pkg::*;
#(
   parameter int FRAME_LEN = FFT_N,
   parameter int TAG_DEPTH = 2,
   parameter int DW        = SAMPLE_W
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          ch0_push,
   input  logic [DW-1:0] ch0_real,
   input  logic [DW-1:0] ch0_imag,
   output logic          ch0_stall,
   input  logic          ch1_push,
   input  logic [DW-1:0] ch1_real,
   input  logic [DW-1:0] ch1_imag,
   output logic          ch1_stall,
   output logic          core_in_push,
   output logic [DW-1:0] core_in_real,
   output logic [DW-1:0] core_in_imag,
   input  logic          core_in_stall,
   input  logic          core_out_push,
   input  logic [DW-1:0] core_out_real,
   input  logic [DW-1:0] core_out_imag,
   output logic          out_push,
   output logic [DW-1:0] out_real,
   output logic [DW-1:0] out_imag,
   output logic          out_chan,
   output logic          err_orphan
);

   localparam int FW = cnt_w(FRAME_LEN);
   localparam int TW = cnt_w(TAG_DEPTH + 1);

   fa_state_e       state_q;
   fa_state_e       state_d;
   logic            grant_ch;
   logic            rr_ptr;
   logic [FW-1:0]   in_cnt;
   logic [FW-1:0]   out_cnt;
   logic [DW-1:0]   held_real;
   logic [DW-1:0]   held_imag;

   logic            sel_push;
   logic [DW-1:0]   sel_real;
   logic [DW-1:0]   sel_imag;
   logic            grant_req;
   logic            grant_sel;
   logic            in_last;
   logic            out_last;

   logic            fifo_head;
   logic            fifo_full;
   logic            fifo_empty;
   logic [TW-1:0]   fifo_count;

   assign sel_push = grant_ch ? ch1_push : ch0_push;
   assign sel_real = grant_ch ? ch1_real : ch0_real;
   assign sel_imag = grant_ch ? ch1_imag : ch0_imag;
   assign in_last  = (in_cnt == FW'(FRAME_LEN - 1));
   assign out_last = (out_cnt == FW'(FRAME_LEN - 1));

   always_ff @(posedge clk) begin
      if (reset) state_q <= FA_IDLE;
      else       state_q <= state_d;
   end

   // Both stalls are forced high while reset is asserted so no sample slips in.
   always_comb begin
      state_d      = state_q;
      ch0_stall    = 1'b1;
      ch1_stall    = 1'b1;
      core_in_push = 1'b0;
      core_in_real = held_real;
      core_in_imag = held_imag;
      grant_req    = 1'b0;
      grant_sel    = 1'b0;
      if (!reset) begin
         case (state_q)
            FA_IDLE: begin
               grant_req = ~fifo_full & (ch0_push | ch1_push);
               grant_sel = (ch0_push & ch1_push) ? rr_ptr : ch1_push;
               if (grant_req) state_d = FA_BUSY;
            end
            FA_BUSY: begin
               if (grant_ch) ch1_stall = core_in_stall;
               else          ch0_stall = core_in_stall;
               core_in_push = sel_push & ~core_in_stall;
               core_in_real = sel_real;
               core_in_imag = sel_imag;
               if (core_in_push && in_last) state_d = FA_IDLE;
            end
            default: state_d = FA_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         grant_ch  <= 1'b0;
         rr_ptr    <= 1'b0;
         in_cnt    <= '0;
         held_real <= '0;
         held_imag <= '0;
      end else begin
         if (grant_req) begin
            grant_ch <= grant_sel;
            in_cnt   <= '0;
         end
         if (core_in_push) begin
            held_real <= sel_real;
            held_imag <= sel_imag;
            if (in_last) begin
               in_cnt <= '0;
               rr_ptr <= ~grant_ch;
            end else begin
               in_cnt <= in_cnt + 1'b1;
            end
         end
      end
   end

   // The tag is read before the end-of-frame pop takes effect, so it still labels the last sample.
   always_ff @(posedge clk) begin
      if (reset) begin
         out_push   <= 1'b0;
         out_real   <= '0;
         out_imag   <= '0;
         out_chan   <= 1'b0;
         err_orphan <= 1'b0;
         out_cnt    <= '0;
      end else begin
         out_push <= core_out_push;
         if (core_out_push) begin
            out_real <= core_out_real;
            out_imag <= core_out_imag;
            out_chan <= (fifo_count != '0) & fifo_head;
            if (fifo_empty) err_orphan <= 1'b1;
            out_cnt  <= out_last ? '0 : out_cnt + 1'b1;
         end
      end
   end

   fft_tag_fifo #(
      .DEPTH (TAG_DEPTH)
   ) u_tag_fifo (
      .clk      (clk),
      .reset    (reset),
      .push     (grant_req),
      .push_tag (grant_sel),
      .pop      (core_out_push & out_last),
      .head     (fifo_head),
      .full     (fifo_full),
      .empty    (fifo_empty),
      .count    (fifo_count)
   );

endmodule

// File: tb/tb_fft_chan_arbiter.sv
// Directed bench for fft_chan_arbiter: a frame/queue level model is checked
// every cycle, plus literal expectations for each scenario.
module tb_fft_chan_arbiter;

   localparam int FRAME_LEN = 16;
   localparam int TAG_DEPTH = 2;
   localparam int DW        = 16;

   logic          clk = 1'b0;
   logic          reset;
   logic          ch0_push, ch1_push;
   logic [DW-1:0] ch0_real, ch0_imag, ch1_real, ch1_imag;
   logic          ch0_stall, ch1_stall;
   logic          core_in_push;
   logic [DW-1:0] core_in_real, core_in_imag;
   logic          core_in_stall;
   logic          core_out_push;
   logic [DW-1:0] core_out_real, core_out_imag;
   logic          out_push;
   logic [DW-1:0] out_real, out_imag;
   logic          out_chan;
   logic          err_orphan;

   int tests = 0;
   int fails = 0;

   // Stimulus bookkeeping
   int       k0, k1;
   bit       chk_en = 0;
   bit       core_echo = 0;
   bit       s_acc0, s_acc1, s_stall0, s_stall1, s_core_push;
   logic [DW-1:0] s_core_real;
   bit       dl_push [3];
   logic [DW-1:0] dl_real [3];

   // Frame-level model state
   int       m_owner;
   int       m_acc;
   bit       m_pref;
   bit       m_tags[$];
   int       m_outcnt;
   logic [DW-1:0] m_held_real, m_held_imag;
   bit       e_out_push, e_out_chan, e_orphan;
   logic [DW-1:0] e_out_real, e_out_imag;

   always #5 clk = ~clk;

   fft_chan_arbiter #(
      .FRAME_LEN (FRAME_LEN),
      .TAG_DEPTH (TAG_DEPTH),
      .DW        (DW)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .ch0_push      (ch0_push),
      .ch0_real      (ch0_real),
      .ch0_imag      (ch0_imag),
      .ch0_stall     (ch0_stall),
      .ch1_push      (ch1_push),
      .ch1_real      (ch1_real),
      .ch1_imag      (ch1_imag),
      .ch1_stall     (ch1_stall),
      .core_in_push  (core_in_push),
      .core_in_real  (core_in_real),
      .core_in_imag  (core_in_imag),
      .core_in_stall (core_in_stall),
      .core_out_push (core_out_push),
      .core_out_real (core_out_real),
      .core_out_imag (core_out_imag),
      .out_push      (out_push),
      .out_real      (out_real),
      .out_imag      (out_imag),
      .out_chan      (out_chan),
      .err_orphan    (err_orphan)
   );

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic driveData();
      ch0_real = DW'(k0);
      ch0_imag = 16'h8000 | DW'(k0);
      ch1_real = 16'h1000 | DW'(k1);
      ch1_imag = 16'h9000 | DW'(k1);
   endtask

   task automatic applyStimulus(input bit p0, input bit p1, input bit cis,
                                input bit cop, input logic [DW-1:0] cor);
      ch0_push      = p0;
      ch1_push      = p1;
      core_in_stall = cis;
      core_out_push = cop;
      core_out_real = cor;
      core_out_imag = ~cor;
      driveData();
   endtask

   task automatic compareAndModel();
      bit e0s, e1s, ep, g, gp, grant, gtag;
      logic [DW-1:0] er, ei;
      e0s = 1; e1s = 1; ep = 0; g = 0; grant = 0; gtag = 0;
      er = m_held_real; ei = m_held_imag;
      if (!reset && m_owner >= 0) begin
         g  = (m_owner == 1);
         gp = g ? ch1_push : ch0_push;
         ep = gp && !core_in_stall;
         if (g) e1s = core_in_stall; else e0s = core_in_stall;
         er = g ? ch1_real : ch0_real;
         ei = g ? ch1_imag : ch0_imag;
      end
      if (chk_en) begin
         checkOutput("ch0_stall", ch0_stall, e0s);
         checkOutput("ch1_stall", ch1_stall, e1s);
         checkOutput("core_in_push", core_in_push, ep);
         checkOutput("core_in_real", core_in_real, er);
         checkOutput("core_in_imag", core_in_imag, ei);
         checkOutput("out_push", out_push, e_out_push);
         checkOutput("out_real", out_real, e_out_real);
         checkOutput("out_imag", out_imag, e_out_imag);
         checkOutput("out_chan", out_chan, e_out_chan);
         checkOutput("err_orphan", err_orphan, e_orphan);
      end
      if (reset) begin
         m_owner = -1; m_acc = 0; m_pref = 0; m_outcnt = 0;
         m_tags.delete();
         m_held_real = '0; m_held_imag = '0;
         e_out_push = 0; e_out_chan = 0; e_orphan = 0;
         e_out_real = '0; e_out_imag = '0;
         return;
      end
      if (m_owner < 0) begin
         if (m_tags.size() < TAG_DEPTH && (ch0_push || ch1_push)) begin
            grant   = 1;
            gtag    = (ch0_push && ch1_push) ? m_pref : ch1_push;
            m_owner = gtag ? 1 : 0;
            m_acc   = 0;
         end
      end else if (ep) begin
         m_held_real = er;
         m_held_imag = ei;
         m_acc++;
         if (m_acc == FRAME_LEN) begin
            m_pref  = !g;
            m_owner = -1;
         end
      end
      e_out_push = core_out_push;
      if (core_out_push) begin
         e_out_real = core_out_real;
         e_out_imag = core_out_imag;
         e_out_chan = (m_tags.size() > 0) ? m_tags[0] : 1'b0;
         if (m_tags.size() == 0) e_orphan = 1;
         m_outcnt++;
         if (m_outcnt == FRAME_LEN) begin
            m_outcnt = 0;
            if (m_tags.size() > 0) void'(m_tags.pop_front());
         end
      end
      if (grant) m_tags.push_back(gtag);
   endtask

   task automatic step();
      @(negedge clk);
      s_acc0      = ch0_push && !ch0_stall;
      s_acc1      = ch1_push && !ch1_stall;
      s_stall0    = ch0_stall;
      s_stall1    = ch1_stall;
      s_core_push = core_in_push;
      s_core_real = core_in_real;
      compareAndModel();
      @(posedge clk);
      #1;
      if (s_acc0) k0++;
      if (s_acc1) k1++;
      if (core_echo) begin
         core_out_push = dl_push[2];
         core_out_real = dl_real[2];
         core_out_imag = ~dl_real[2];
         dl_push[2] = dl_push[1]; dl_real[2] = dl_real[1];
         dl_push[1] = dl_push[0]; dl_real[1] = dl_real[0];
         dl_push[0] = s_core_push; dl_real[0] = s_core_real;
      end
      driveData();
   endtask

   task automatic doReset();
      reset = 1;
      core_echo = 0;
      k0 = 0; k1 = 0;
      for (int i = 0; i < 3; i++) begin dl_push[i] = 0; dl_real[i] = '0; end
      applyStimulus(0, 0, 0, 0, '0);
      step();
      step();
      reset = 0;
   endtask

   initial begin
      int cycles, first, bad, viol, held_acc, started;
      bit own[$];

      doReset();
      chk_en = 1;
      doReset();
      checkOutput("rst_ch0_stall", ch0_stall, 1);
      checkOutput("rst_ch1_stall", ch1_stall, 1);
      checkOutput("rst_core_in_push", core_in_push, 0);
      checkOutput("rst_out_push", out_push, 0);
      checkOutput("rst_out_chan", out_chan, 0);
      checkOutput("rst_err_orphan", err_orphan, 0);
      checkOutput("rst_core_in_real", core_in_real, 0);

      // Single ch0 frame: one IDLE grant cycle then 16 back-to-back accepts.
      applyStimulus(1, 0, 0, 0, '0);
      cycles = 0; first = -1; bad = 0;
      while (k0 < FRAME_LEN && cycles < 40) begin
         step();
         if (s_acc0 && first < 0) first = cycles;
         if (!s_stall1) bad++;
         cycles++;
      end
      applyStimulus(0, 0, 0, 0, '0);
      checkOutput("t1_accepts", k0, 16);
      checkOutput("t1_first_accept_cycle", first, 1);
      checkOutput("t1_frame_cycles", cycles, 17);
      checkOutput("t1_ch1_never_unstalled", bad, 0);
      step();
      checkOutput("t1_idle_ch0_stall", ch0_stall, 1);
      checkOutput("t1_held_real", core_in_real, 16'h000F);

      // Both channels request continuously; core echoes input after a few cycles.
      doReset();
      core_echo = 1;
      applyStimulus(1, 1, 0, 0, '0);
      cycles = 0;
      own.delete();
      while (own.size() < 64 && cycles < 300) begin
         step();
         if (s_acc0) own.push_back(1'b0);
         if (s_acc1) own.push_back(1'b1);
         cycles++;
      end
      applyStimulus(0, 0, 0, 0, '0);
      for (int i = 0; i < 8; i++) step();
      checkOutput("t2_accepts", own.size(), 64);
      viol = 0;
      foreach (own[i]) if (own[i] != bit'((i / FRAME_LEN) % 2)) viol++;
      checkOutput("t2_frame_owner_violations", viol, 0);
      checkOutput("t2_first_owner", (own.size() > 0) ? 32'(own[0]) : 32'd2, 0);
      checkOutput("t2_period", cycles, 4 * (FRAME_LEN + 1));

      // ch1 frame with core_in_stall during frame cycles 5..8.
      doReset();
      applyStimulus(0, 1, 0, 0, '0);
      cycles = 0; bad = 0;
      while (k1 < FRAME_LEN && cycles < 60) begin
         core_in_stall = (cycles >= 5 && cycles <= 8);
         step();
         if (cycles >= 5 && cycles <= 8 && (!s_stall1 || s_acc1)) bad++;
         cycles++;
      end
      applyStimulus(0, 0, 0, 0, '0);
      checkOutput("t3_accepts", k1, 16);
      checkOutput("t3_stalled_cycles_ok", bad, 0);
      checkOutput("t3_frame_cycles", cycles, 21);
      step();
      checkOutput("t3_idle_ch1_stall", ch1_stall, 1);

      // Two frames in flight fill the tag FIFO; the third request waits for a pop.
      doReset();
      applyStimulus(0, 1, 0, 0, '0);
      cycles = 0;
      while (k1 < FRAME_LEN && cycles < 40) begin step(); cycles++; end
      applyStimulus(1, 1, 0, 0, '0);
      cycles = 0;
      while (k0 < FRAME_LEN && cycles < 40) begin step(); cycles++; end
      checkOutput("t4_second_frame_ch0", k0, 16);
      held_acc = 0;
      for (int i = 0; i < 8; i++) begin
         step();
         if (s_acc0 || s_acc1) held_acc++;
      end
      checkOutput("t4_held_while_full", held_acc, 0);
      for (int i = 0; i < FRAME_LEN; i++) begin
         applyStimulus(1, 1, 0, 1, DW'(16'h0A00 + i));
         step();
         checkOutput("t4_out_push", out_push, 1);
         checkOutput("t4_out_chan", out_chan, 1);
      end
      checkOutput("t4_out_real_last", out_real, 16'h0A0F);
      applyStimulus(1, 1, 0, 0, '0);
      cycles = 0; started = 0;
      while (k1 == FRAME_LEN && cycles < 10) begin step(); cycles++; end
      checkOutput("t4_regrant_ch1", k1, 17);
      checkOutput("t4_regrant_latency", cycles, 2);

      // End-of-frame pop coincides with a grant: occupancy stays at one.
      doReset();
      applyStimulus(1, 0, 0, 0, '0);
      cycles = 0;
      while (k0 < FRAME_LEN && cycles < 40) begin step(); cycles++; end
      applyStimulus(0, 0, 0, 0, '0);
      step();
      for (int i = 0; i < FRAME_LEN - 1; i++) begin
         applyStimulus(0, 0, 0, 1, DW'(i));
         step();
      end
      applyStimulus(0, 1, 0, 1, 16'h00EE);
      step();
      checkOutput("t5_last_sample_chan", out_chan, 0);
      checkOutput("t5_last_sample_real", out_real, 16'h00EE);
      applyStimulus(0, 1, 0, 0, '0);
      cycles = 0;
      while (k1 < FRAME_LEN && cycles < 40) begin step(); cycles++; end
      checkOutput("t5_ch1_accepts", k1, 16);
      for (int i = 0; i < FRAME_LEN; i++) begin
         applyStimulus(0, 0, 0, 1, DW'(16'h0B00 + i));
         step();
         checkOutput("t5_out_chan_ch1", out_chan, 1);
      end
      checkOutput("t5_no_orphan", err_orphan, 0);

      // Orphan output after reset, then reset asserted mid-frame.
      doReset();
      applyStimulus(0, 0, 0, 1, 16'h1234);
      step();
      applyStimulus(0, 0, 0, 0, '0);
      checkOutput("t6_orphan_set", err_orphan, 1);
      checkOutput("t6_orphan_chan", out_chan, 0);
      checkOutput("t6_orphan_push", out_push, 1);
      checkOutput("t6_orphan_real", out_real, 16'h1234);
      step();
      checkOutput("t6_orphan_sticky", err_orphan, 1);
      checkOutput("t6_out_real_hold", out_real, 16'h1234);
      checkOutput("t6_out_push_low", out_push, 0);
      applyStimulus(1, 0, 0, 1, 16'h0055);
      for (int i = 0; i < 5; i++) step();
      checkOutput("t6_midframe_accepts", k0, 4);
      reset = 1;
      step();
      checkOutput("t6_rst_ch0_stall", ch0_stall, 1);
      checkOutput("t6_rst_ch1_stall", ch1_stall, 1);
      checkOutput("t6_rst_out_push", out_push, 0);
      checkOutput("t6_rst_err_orphan", err_orphan, 0);
      checkOutput("t6_rst_out_real", out_real, 0);
      reset = 0;
      applyStimulus(0, 0, 0, 0, '0);
      step();
      checkOutput("t6_post_ch0_stall", ch0_stall, 1);
      checkOutput("t6_post_core_in_real", core_in_real, 0);
      checkOutput("t6_post_out_chan", out_chan, 0);
      step();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
